// File: rtl/s526_tb_pkg.sv
// Shared definitions for the s526 response compactor: FSM states, response
// width, default MISR constants and the bit position of each captured output.
package s526_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RESP_W = 6;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  // Position of each s526 primary output inside resp_data.
  localparam int G147_BIT = 0;
  localparam int G148_BIT = 1;
  localparam int G198_BIT = 2;
  localparam int G199_BIT = 3;
  localparam int G213_BIT = 4;
  localparam int G214_BIT = 5;

endpackage

// File: rtl/s526_misr_reg.sv
// Multiple-input signature register. Shifts toward the MSB, feeds the MSB back
// through POLY and XORs the zero-extended response word into the low bits.
// seed_load takes priority over step_en.
module s526_misr_reg
  import s526_tb_pkg::*;
#(
  parameter int              W    = 16,
  parameter logic [W-1:0]    POLY = W'(DEF_POLY),
  parameter logic [W-1:0]    SEED = W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic              step_en,
  input  logic [RESP_W-1:0] data,
  output logic [W-1:0]      sig
);

  logic [W-1:0] sig_step;

  // One compaction step from the current signature.
  always_comb begin
    sig_step = {sig[W-2:0], 1'b0}
             ^ (sig[W-1] ? POLY : '0)
             ^ {{(W-RESP_W){1'b0}}, data};
  end

  // Signature register: seed on run start, step on each accepted response.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (seed_load) begin
      sig <= SEED;
    end else if (step_en) begin
      sig <= sig_step;
    end
  end

endmodule

// File: rtl/s526_resp_misr.sv
// Response compactor for the s526 benchmark: accepts num_pat response words,
// folds them into a MISR and compares the final signature with exp_sig.
// Optional build macro: S526_MISR_XMASK_EN adds resp_xmask, which zeroes
// unknown-value response bits before compaction.
module s526_resp_misr
  import s526_tb_pkg::*;
#(
  parameter int                 MISR_W = 16,
  parameter logic [MISR_W-1:0]  POLY   = MISR_W'(DEF_POLY),
  parameter logic [MISR_W-1:0]  SEED   = MISR_W'(DEF_SEED),
  parameter int                 CNT_W  = 16
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic [MISR_W-1:0] exp_sig,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [RESP_W-1:0] resp_data,
`ifdef S526_MISR_XMASK_EN
  input  logic [RESP_W-1:0] resp_xmask,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] sig,
  output logic [CNT_W-1:0]  pat_cnt
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_pat_q;
  logic [MISR_W-1:0] exp_sig_q;
  logic              start_acc;
  logic              accept;
  logic              last_accept;
  logic [RESP_W-1:0] data_eff;

  // Handshake and run-control decode; ready/busy come from the state flop only.
  always_comb begin
    resp_ready  = (state_q == RUN);
    busy        = (state_q == RUN) || (state_q == CHECK);
    start_acc   = start && ((state_q == IDLE) || (state_q == DONE));
    accept      = resp_valid && resp_ready;
    last_accept = accept && ((pat_cnt + CNT_W'(1)) == num_pat_q);
  end

  // Response word after optional X masking.
`ifdef S526_MISR_XMASK_EN
  always_comb data_eff = resp_data & ~resp_xmask;
`else
  always_comb data_eff = resp_data;
`endif

  // Next-state logic.
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_acc) state_d = (num_pat == '0) ? CHECK : RUN;
      RUN:        if (last_accept) state_d = CHECK;
      CHECK:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Run parameters captured on an accepted start.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      num_pat_q <= '0;
      exp_sig_q <= '0;
    end else if (start_acc) begin
      num_pat_q <= num_pat;
      exp_sig_q <= exp_sig;
    end
  end

  // Pattern counter; the run ends exactly at num_pat so it never wraps.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)          pat_cnt <= '0;
    else if (start_acc) pat_cnt <= '0;
    else if (accept)    pat_cnt <= pat_cnt + CNT_W'(1);
  end

  // Result flags: cleared on a new run, registered once in CHECK, held in DONE.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (start_acc) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state_q == CHECK) begin
      done <= 1'b1;
      pass <= (sig == exp_sig_q);
    end
  end

  s526_misr_reg #(
    .W    (MISR_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk       (CK),
    .rst_n     (RSTN),
    .seed_load (start_acc),
    .step_en   (accept),
    .data      (data_eff),
    .sig       (sig)
  );

endmodule

// File: tb/tb_s526_resp_misr.sv
// Self-checking bench for s526_resp_misr. Expected results are produced by a
// bench-side MISR model, queued when a run is launched and popped on done.
module tb_s526_resp_misr;

  logic        CK;
  logic        RSTN;
  logic        start;
  logic [15:0] num_pat;
  logic [15:0] exp_sig;
  logic        resp_valid;
  logic        resp_ready;
  logic [5:0]  resp_data;
  logic [5:0]  resp_xmask;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] sig;
  logic [15:0] pat_cnt;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  stim[16];
  logic [15:0] golden;

  s526_resp_misr dut (
    .CK         (CK),
    .RSTN       (RSTN),
    .start      (start),
    .num_pat    (num_pat),
    .exp_sig    (exp_sig),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef S526_MISR_XMASK_EN
    .resp_xmask (resp_xmask),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .sig        (sig),
    .pat_cnt    (pat_cnt)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Count every handshake the DUT takes.
  always @(posedge CK) if (RSTN && resp_valid && resp_ready) acc_cnt++;

  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [5:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    return n ^ {10'h000, d};
  endfunction

  // Launch a run from IDLE/DONE, feed stim[0..n-1], then check the result.
  task automatic do_run(input int n, input logic [15:0] es, input bit gaps,
                        input logic [5:0] xm, output logic [15:0] got_sig);
    logic [15:0] s;
    exp_t        e;
    int          i, cyc, w, acc0;
    s = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      logic [5:0] dm;
`ifdef S526_MISR_XMASK_EN
      dm = stim[k] & ~xm;
`else
      dm = stim[k];
`endif
      s = model_step(s, dm);
    end
    e.sig = s; e.pass = (s == es); e.cnt = 16'(n);
    sb.push_back(e);

    resp_xmask = xm;
    @(negedge CK);
    start = 1'b1; num_pat = 16'(n); exp_sig = es;
    @(negedge CK);
    start = 1'b0; num_pat = 16'hDEAD; exp_sig = 16'h0000;
    acc0 = acc_cnt;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sig !== 16'hFFFF || pat_cnt !== 16'h0) begin
      failures++;
      $display("FAIL run_start n=%0d: done=%b busy=%b sig=%h cnt=%0d, required done=0 busy=1 sig=ffff cnt=0",
               n, done, busy, sig, pat_cnt);
    end

    i = 0; cyc = 0;
    while (i < n && cyc < 200) begin
      resp_valid = gaps ? cyc[0] : 1'b1;
      resp_data  = stim[i];
      if (resp_valid && resp_ready) i++;
      @(negedge CK);
      cyc++;
    end
    // Keep offering words to prove CHECK/DONE never consume them.
    resp_valid = 1'b1;
    resp_data  = 6'h2A;
    w = 0;
    while (done !== 1'b1 && w < 10) begin
      @(negedge CK);
      w++;
    end
    checks++;
    if (w != 1) begin
      failures++;
      $display("FAIL done_latency n=%0d: cycles=%0d, required 1 after last accept/start", n, w);
    end
    repeat (2) @(negedge CK);
    resp_valid = 1'b0;

    e = sb.pop_front();
    checks++;
    if (sig !== e.sig || pass !== e.pass || pat_cnt !== e.cnt || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_result n=%0d: sig=%h pass=%b cnt=%0d done=%b busy=%b, required sig=%h pass=%b cnt=%0d done=1 busy=0",
               n, sig, pass, pat_cnt, done, busy, e.sig, e.pass, e.cnt);
    end
    checks++;
    if (acc_cnt - acc0 != n) begin
      failures++;
      $display("FAIL accept_count n=%0d: accepts=%0d, required %0d", n, acc_cnt - acc0, n);
    end
    got_sig = sig;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; start = 1'b0; num_pat = '0; exp_sig = '0;
    resp_valid = 1'b0; resp_data = '0; resp_xmask = '0;
    #12;
    checks++;
    if (resp_ready !== 0 || busy !== 0 || done !== 0 || pass !== 0 || sig !== 16'hFFFF || pat_cnt !== 0) begin
      failures++;
      $display("FAIL reset_values: ready=%b busy=%b done=%b pass=%b sig=%h cnt=%0d, required 0 0 0 0 ffff 0",
               resp_ready, busy, done, pass, sig, pat_cnt);
    end
    @(negedge CK);
    RSTN = 1'b1;
  endtask

  task automatic test_zero_pat();
    logic [15:0] g;
    do_run(0, 16'hFFFF, 1'b0, 6'h00, g);
    checks++;
    if (g !== 16'hFFFF || pass !== 1'b1) begin
      failures++;
      $display("FAIL zero_pat: sig=%h pass=%b, required ffff 1", g, pass);
    end
  endtask

  task automatic test_single();
    logic [15:0] g;
    stim[0] = 6'h00;
    do_run(1, 16'hEFDF, 1'b0, 6'h00, g);
    checks++;
    if (g !== 16'hEFDF || pass !== 1'b1 || pat_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_zero: sig=%h pass=%b cnt=%0d, required efdf 1 1", g, pass, pat_cnt);
    end
    stim[0] = 6'h3F;
    do_run(1, 16'hEFDF, 1'b0, 6'h00, g);
    checks++;
    if (g !== 16'hEFE0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL single_ones: sig=%h pass=%b, required efe0 0", g, pass);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] g0, g1;
    stim[0] = 6'h15; stim[1] = 6'h2A; stim[2] = 6'h01; stim[3] = 6'h20;
    do_run(4, 16'h0000, 1'b0, 6'h00, g0);
    do_run(4, g0, 1'b1, 6'h00, g1);
    checks++;
    if (g1 !== g0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL gap_vs_nogap: sig=%h pass=%b, required %h 1", g1, pass, g0);
    end
  endtask

  task automatic test_reset_mid_run();
    int          i, cyc;
    logic [15:0] g;
    for (int k = 0; k < 5; k++) stim[k] = 6'(k * 7 + 3);
    golden = 16'hFFFF;
    for (int k = 0; k < 5; k++) golden = model_step(golden, stim[k]);
    @(negedge CK);
    start = 1'b1; num_pat = 16'd5; exp_sig = golden;
    @(negedge CK);
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < 2 && cyc < 20) begin
      resp_valid = 1'b1; resp_data = stim[i];
      if (resp_ready) i++;
      @(negedge CK);
      cyc++;
    end
    resp_valid = 1'b0;
    checks++;
    if (pat_cnt !== 16'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort: cnt=%0d busy=%b, required 2 1", pat_cnt, busy);
    end
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if (sig !== 16'hFFFF || pat_cnt !== 0 || busy !== 0 || done !== 0 || resp_ready !== 0) begin
      failures++;
      $display("FAIL abort_reset: sig=%h cnt=%0d busy=%b done=%b ready=%b, required ffff 0 0 0 0",
               sig, pat_cnt, busy, done, resp_ready);
    end
    @(negedge CK);
    RSTN = 1'b1;
    do_run(5, golden, 1'b0, 6'h00, g);
    checks++;
    if (g !== golden || pass !== 1'b1) begin
      failures++;
      $display("FAIL rerun_after_abort: sig=%h pass=%b, required %h 1", g, pass, golden);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g;
    for (int k = 0; k < 8; k++) stim[k] = 6'($urandom_range(0, 63));
    do_run(8, 16'h1234, 1'b0, 6'h00, g);
    do_run(3, 16'h5555, 1'b1, 6'h00, g);
    do_run(0, 16'h0000, 1'b0, 6'h00, g);
  endtask

`ifdef S526_MISR_XMASK_EN
  task automatic test_mask();
    logic [15:0] g;
    stim[0] = 6'h3F;
    do_run(1, 16'hEFDF, 1'b0, 6'h3F, g);
    checks++;
    if (g !== 16'hEFDF || pass !== 1'b1) begin
      failures++;
      $display("FAIL mask_all: sig=%h pass=%b, required efdf 1", g, pass);
    end
    stim[0] = 6'h3F;
    do_run(1, 16'h0000, 1'b0, 6'h0F, g);
    resp_xmask = 6'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_pat();
    test_single();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef S526_MISR_XMASK_EN
    test_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
